// File: rtl/probe_unit_pkg.sv
// Shared probe/metadata definitions: FSM states, TileLink C-channel opcodes,
// probe cap and report encodings, client coherence states and the shrink table.
package probe_unit_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StMetaRd,
        StMetaResp,
        StMshrWait,
        StData,
        StAck,
        StMetaWr
    } probe_state_e;

    // C-channel opcodes
    localparam logic [2:0] TlProbeAck     = 3'd4;
    localparam logic [2:0] TlProbeAckData = 3'd5;

    // B-channel cap parameter; 3 is not defined and is handled as toN
    localparam logic [1:0] CapToT = 2'd0;
    localparam logic [1:0] CapToB = 2'd1;
    localparam logic [1:0] CapToN = 2'd2;

    // C-channel report parameter
    localparam logic [2:0] RepTtoB = 3'd0;
    localparam logic [2:0] RepTtoN = 3'd1;
    localparam logic [2:0] RepBtoN = 3'd2;
    localparam logic [2:0] RepTtoT = 3'd3;
    localparam logic [2:0] RepBtoB = 3'd4;
    localparam logic [2:0] RepNtoN = 3'd5;

    // Client coherence states
    localparam logic [1:0] CohNothing = 2'd0;
    localparam logic [1:0] CohBranch  = 2'd1;
    localparam logic [1:0] CohTrunk   = 2'd2;
    localparam logic [1:0] CohDirty   = 2'd3;

    typedef struct packed {
        logic       has_data;
        logic [2:0] report;
        logic [1:0] new_coh;
    } shrink_t;

    // Shrink the client state to the probe cap; Dirty lines return their data.
    function automatic shrink_t shrink(input logic [1:0] cap, input logic [1:0] coh);
        shrink_t r;
        r = '{1'b0, RepNtoN, CohNothing};
        case (cap)
            CapToT: begin
                case (coh)
                    CohDirty:  r = '{1'b1, RepTtoT, CohTrunk};
                    CohTrunk:  r = '{1'b0, RepTtoT, CohTrunk};
                    CohBranch: r = '{1'b0, RepBtoB, CohBranch};
                    default:   r = '{1'b0, RepNtoN, CohNothing};
                endcase
            end
            CapToB: begin
                case (coh)
                    CohDirty:  r = '{1'b1, RepTtoB, CohBranch};
                    CohTrunk:  r = '{1'b0, RepTtoB, CohBranch};
                    CohBranch: r = '{1'b0, RepBtoB, CohBranch};
                    default:   r = '{1'b0, RepNtoN, CohNothing};
                endcase
            end
            default: begin
                case (coh)
                    CohDirty:  r = '{1'b1, RepTtoN, CohNothing};
                    CohTrunk:  r = '{1'b0, RepTtoN, CohNothing};
                    CohBranch: r = '{1'b0, RepBtoN, CohNothing};
                    default:   r = '{1'b0, RepNtoN, CohNothing};
                endcase
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/probe_beat_buf.sv
// One-entry holding register for a C-channel data beat with valid/ready on
// both sides. Contents stay stable while the consumer stalls.
module probe_beat_buf #(
    parameter int unsigned DATA_W = 64
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    logic              full_q;
    logic [DATA_W-1:0] data_q;

    // Fill when empty, drain on consumer handshake.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else if (in_valid && in_ready) begin
            full_q <= 1'b1;
            data_q <= in_data;
        end else if (out_valid && out_ready) begin
            full_q <= 1'b0;
        end
    end

    assign in_ready  = !full_q;
    assign out_valid = full_q;
    assign out_data  = data_q;

endmodule

// File: rtl/probe_unit.sv
// L1 data cache probe unit: services one TileLink B-channel probe at a time,
// reads the metadata, shrinks the client state, returns ProbeAck/ProbeAckData
// on channel C and writes back the new coherence state.
// Optional macro PROBE_UNIT_PERF_EN adds saturating probe/stall counters.
module probe_unit
    import probe_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned BEATS  = 8,
    parameter int unsigned WAYS   = 4,
    parameter int unsigned IDX_W  = 6,
    parameter int unsigned SRC_W  = 4,
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [1:0]        b_param,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [SRC_W-1:0]  b_source,
    output logic              meta_req_valid,
    input  logic              meta_req_ready,
    output logic [IDX_W-1:0]  meta_req_idx,
    input  logic [WAYS-1:0]   meta_resp_hit,
    input  logic [1:0]        meta_resp_coh,
    input  logic              mshr_block,
    output logic              data_req_valid,
    input  logic              data_req_ready,
    output logic [WAYS-1:0]   data_req_way,
    output logic [BEAT_W-1:0] data_req_beat,
    input  logic [DATA_W-1:0] data_resp,
    output logic              c_valid,
    input  logic              c_ready,
    output logic [2:0]        c_opcode,
    output logic [2:0]        c_param,
    output logic [ADDR_W-1:0] c_addr,
    output logic [SRC_W-1:0]  c_source,
    output logic [DATA_W-1:0] c_data,
    output logic              meta_wr_valid,
    input  logic              meta_wr_ready,
    output logic [WAYS-1:0]   meta_wr_way,
    output logic [1:0]        meta_wr_coh,
    output logic              busy,
    output logic              lsu_release
`ifdef PROBE_UNIT_PERF_EN
    ,
    output logic [31:0]       probe_cnt,
    output logic [31:0]       probe_data_cnt,
    output logic [31:0]       stall_cyc
`endif
);

    // Byte offset of a cache line inside the address
    localparam int unsigned OFF_W = $clog2(BEATS * DATA_W / 8);
    localparam logic [BEAT_W-1:0] LastBeat = BEAT_W'(BEATS - 1);

    probe_state_e      state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        cap_q;
    logic [SRC_W-1:0]  src_q;
    logic [WAYS-1:0]   hit_q;
    logic [1:0]        coh_q;
    logic [1:0]        new_coh_q;
    logic [2:0]        report_q;
    logic              has_data_q;
    logic [BEAT_W-1:0] beat_q;
    logic              pend_q;   // data response arrives this cycle

    logic              b_fire, meta_fire, data_fire, c_fire, wr_fire;
    logic              last_fire, coh_change, need_wr;
    logic [1:0]        resp_coh;
    shrink_t           shr;
    logic              buf_in_ready, buf_valid;
    logic [DATA_W-1:0] buf_data;

    assign b_fire     = b_valid && b_ready;
    assign meta_fire  = meta_req_valid && meta_req_ready;
    assign data_fire  = data_req_valid && data_req_ready;
    assign c_fire     = c_valid && c_ready;
    assign wr_fire    = meta_wr_valid && meta_wr_ready;
    assign resp_coh   = (|meta_resp_hit) ? meta_resp_coh : CohNothing;
    assign shr        = shrink(cap_q, resp_coh);
    assign coh_change = (new_coh_q != coh_q);
    assign need_wr    = (|hit_q) && coh_change;
    assign last_fire  = c_fire && ((state_q == StAck) || (beat_q == LastBeat));

    // Probe sequencer and its latched context.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            cap_q      <= '0;
            src_q      <= '0;
            hit_q      <= '0;
            coh_q      <= '0;
            new_coh_q  <= '0;
            report_q   <= '0;
            has_data_q <= 1'b0;
            beat_q     <= '0;
            pend_q     <= 1'b0;
        end else begin
            pend_q <= data_fire;
            case (state_q)
                StIdle: begin
                    if (b_fire) begin
                        addr_q  <= b_addr;
                        cap_q   <= b_param;
                        src_q   <= b_source;
                        state_q <= StMetaRd;
                    end
                end
                StMetaRd: begin
                    if (meta_fire) state_q <= StMetaResp;
                end
                StMetaResp: begin
                    hit_q      <= meta_resp_hit;
                    coh_q      <= resp_coh;
                    new_coh_q  <= shr.new_coh;
                    report_q   <= shr.report;
                    has_data_q <= shr.has_data;
                    state_q    <= StMshrWait;
                end
                StMshrWait: begin
                    beat_q <= '0;
                    if (!mshr_block) state_q <= has_data_q ? StData : StAck;
                end
                StData: begin
                    if (c_fire) beat_q <= (beat_q == LastBeat) ? '0 : beat_q + 1'b1;
                    if (last_fire) state_q <= need_wr ? StMetaWr : StIdle;
                end
                StAck: begin
                    if (c_fire) state_q <= need_wr ? StMetaWr : StIdle;
                end
                StMetaWr: begin
                    if (wr_fire) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Only one beat outstanding: issue again once the previous beat has left.
    probe_beat_buf #(
        .DATA_W (DATA_W)
    ) u_beat_buf (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (pend_q),
        .in_ready  (buf_in_ready),
        .in_data   (data_resp),
        .out_valid (buf_valid),
        .out_ready (c_ready && (state_q == StData)),
        .out_data  (buf_data)
    );

    assign b_ready        = (state_q == StIdle);
    assign busy           = (state_q != StIdle);
    assign meta_req_valid = (state_q == StMetaRd);
    assign meta_req_idx   = addr_q[OFF_W +: IDX_W];
    assign data_req_valid = (state_q == StData) && !pend_q && buf_in_ready;
    assign data_req_way   = hit_q;
    assign data_req_beat  = beat_q;
    assign c_valid        = (state_q == StAck) || ((state_q == StData) && buf_valid);
    assign c_opcode       = (state_q == StData) ? TlProbeAckData : TlProbeAck;
    assign c_param        = report_q;
    assign c_addr         = addr_q;
    assign c_source       = src_q;
    assign c_data         = (state_q == StData) ? buf_data : '0;
    assign meta_wr_valid  = (state_q == StMetaWr);
    assign meta_wr_way    = hit_q;
    assign meta_wr_coh    = new_coh_q;
    assign lsu_release    = last_fire && coh_change;

`ifdef PROBE_UNIT_PERF_EN
    // Saturating event counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            probe_cnt      <= '0;
            probe_data_cnt <= '0;
            stall_cyc      <= '0;
        end else begin
            if (b_fire && (probe_cnt != '1)) probe_cnt <= probe_cnt + 1'b1;
            if ((state_q == StMshrWait) && !mshr_block && has_data_q &&
                (probe_data_cnt != '1)) begin
                probe_data_cnt <= probe_data_cnt + 1'b1;
            end
            if (((state_q == StMshrWait) || (c_valid && !c_ready)) && (stall_cyc != '1)) begin
                stall_cyc <= stall_cyc + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_probe_unit.sv
module tb_probe_unit;

    localparam int BEATS = 8;

    logic        clock, reset_n;
    logic        b_valid, b_ready;
    logic [1:0]  b_param;
    logic [31:0] b_addr;
    logic [3:0]  b_source;
    logic        meta_req_valid, meta_req_ready;
    logic [5:0]  meta_req_idx;
    logic [3:0]  meta_resp_hit;
    logic [1:0]  meta_resp_coh;
    logic        mshr_block;
    logic        data_req_valid, data_req_ready;
    logic [3:0]  data_req_way;
    logic [2:0]  data_req_beat;
    logic [63:0] data_resp;
    logic        c_valid, c_ready;
    logic [2:0]  c_opcode, c_param;
    logic [31:0] c_addr;
    logic [3:0]  c_source;
    logic [63:0] c_data;
    logic        meta_wr_valid, meta_wr_ready;
    logic [3:0]  meta_wr_way;
    logic [1:0]  meta_wr_coh;
    logic        busy, lsu_release;

    probe_unit dut (
        .clock(clock), .reset_n(reset_n),
        .b_valid(b_valid), .b_ready(b_ready), .b_param(b_param), .b_addr(b_addr),
        .b_source(b_source),
        .meta_req_valid(meta_req_valid), .meta_req_ready(meta_req_ready),
        .meta_req_idx(meta_req_idx), .meta_resp_hit(meta_resp_hit),
        .meta_resp_coh(meta_resp_coh), .mshr_block(mshr_block),
        .data_req_valid(data_req_valid), .data_req_ready(data_req_ready),
        .data_req_way(data_req_way), .data_req_beat(data_req_beat), .data_resp(data_resp),
        .c_valid(c_valid), .c_ready(c_ready), .c_opcode(c_opcode), .c_param(c_param),
        .c_addr(c_addr), .c_source(c_source), .c_data(c_data),
        .meta_wr_valid(meta_wr_valid), .meta_wr_ready(meta_wr_ready),
        .meta_wr_way(meta_wr_way), .meta_wr_coh(meta_wr_coh),
        .busy(busy), .lsu_release(lsu_release)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  param;
        logic [31:0] addr;
        logic [3:0]  src;
        logic [63:0] data;
    } beat_t;

    typedef struct {
        logic [1:0] cap;
        int         way;
        logic [1:0] coh;
        bit         data;
        logic [2:0] param;
        bit         wr;
        logic [1:0] ncoh;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Environment configuration for the current probe
    logic [63:0] line [BEATS];
    logic [3:0]  hit_vec;
    logic [1:0]  cfg_coh;
    int          cfg_k;
    bit          cfg_rnd;

    // Observations
    int          cyc = 0;
    int          b_fire_cyc, first_c;
    bit          b_drop, meta_pend, data_pend, hold_valid;
    logic [2:0]  data_pend_beat;
    logic [5:0]  idx_seen;
    beat_t       hold, cur;
    beat_t       beats[$];
    int          dreq_cnt, order_err, stab_err, lsu_cnt, lsu_bad, wr_cnt;
    logic [3:0]  wr_way;
    logic [1:0]  wr_coh;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: rank states N<B<T (Dirty ranks as T), new rank = min(rank, cap rank).
    function automatic void ref_probe(input logic [1:0] cap, input logic [1:0] coh,
                                      output bit has_data, output logic [2:0] report,
                                      output logic [1:0] new_coh);
        int lvl, cap_lvl, nl;
        lvl     = (coh == 2'd3) ? 2 : int'(coh);
        cap_lvl = (cap == 2'd0) ? 2 : (cap == 2'd1) ? 1 : 0;
        nl      = (lvl < cap_lvl) ? lvl : cap_lvl;
        has_data = (coh == 2'd3);
        new_coh  = 2'(nl);
        if (lvl == 2)      report = (nl == 2) ? 3'd3 : (nl == 1) ? 3'd0 : 3'd1;
        else if (lvl == 1) report = (nl == 1) ? 3'd4 : 3'd2;
        else               report = 3'd5;
    endfunction

    // One clock: drive responses at the falling edge, then record what fires next edge.
    task automatic step();
        @(negedge clock);
        cyc++;
        if (b_drop) begin
            b_valid = 1'b0;
            b_drop  = 1'b0;
        end
        meta_resp_hit  = meta_pend ? hit_vec : 4'($urandom);
        meta_resp_coh  = meta_pend ? cfg_coh : 2'($urandom);
        data_resp      = data_pend ? line[data_pend_beat] : {$urandom, $urandom};
        c_ready        = cfg_rnd ? 1'($urandom) : 1'b1;
        meta_req_ready = cfg_rnd ? 1'($urandom) : 1'b1;
        data_req_ready = cfg_rnd ? 1'($urandom) : 1'b1;
        meta_wr_ready  = cfg_rnd ? 1'($urandom) : 1'b1;
        mshr_block     = (b_fire_cyc >= 0) && (cyc - b_fire_cyc >= 1) &&
                         (cyc - b_fire_cyc <= cfg_k);
        #1;
        if (b_valid && b_ready) begin
            b_fire_cyc = cyc;
            b_drop     = 1'b1;
        end
        meta_pend = meta_req_valid && meta_req_ready;
        if (meta_pend) idx_seen = meta_req_idx;
        data_pend = data_req_valid && data_req_ready;
        if (data_pend) begin
            if (data_req_beat != 3'(dreq_cnt % BEATS) || data_req_way != hit_vec) order_err++;
            data_pend_beat = data_req_beat;
            dreq_cnt++;
        end
        if (c_valid) begin
            cur = '{c_opcode, c_param, c_addr, c_source, c_data};
            if (first_c < 0) first_c = cyc;
            if (hold_valid && (cur.data !== hold.data || cur.op !== hold.op ||
                               cur.param !== hold.param)) stab_err++;
            if (c_ready) begin
                beats.push_back(cur);
                hold_valid = 1'b0;
            end else begin
                hold_valid = 1'b1;
                hold       = cur;
            end
        end else if (hold_valid) begin
            stab_err++;
            hold_valid = 1'b0;
        end
        if (lsu_release) begin
            lsu_cnt++;
            if (!(c_valid && c_ready)) lsu_bad++;
        end
        if (meta_wr_valid && meta_wr_ready) begin
            wr_cnt++;
            wr_way = meta_wr_way;
            wr_coh = meta_wr_coh;
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " busy"}, busy, 1'b0);
        chk({tag, " b_ready"}, b_ready, 1'b1);
        chk({tag, " valids"}, {c_valid, meta_req_valid, data_req_valid, meta_wr_valid}, 4'h0);
        chk({tag, " lsu_release"}, lsu_release, 1'b0);
    endtask

    task automatic run_probe(input logic [1:0] cap, input int way, input logic [1:0] coh,
                             input int k, input bit rnd, input int abort_beat,
                             input bit exp_data, input logic [2:0] exp_param,
                             input bit exp_wr, input logic [1:0] exp_coh, input string tag);
        int t;
        int n_exp;
        logic [31:0] addr;
        logic [3:0]  src;
        cfg_coh = coh;
        hit_vec = (way < 0) ? 4'h0 : 4'(1 << way);
        cfg_k   = k;
        cfg_rnd = rnd;
        for (int i = 0; i < BEATS; i++) line[i] = {$urandom, $urandom};
        addr = $urandom & 32'hffff_ffc0;
        src  = 4'($urandom);
        beats.delete();
        b_fire_cyc = -1; first_c = -1;
        dreq_cnt = 0; order_err = 0; stab_err = 0; lsu_cnt = 0; lsu_bad = 0; wr_cnt = 0;
        wr_way = 'x; wr_coh = 'x; idx_seen = 'x; hold_valid = 1'b0;
        b_valid = 1'b1; b_param = cap; b_addr = addr; b_source = src;
        if (b_ready) begin
            b_fire_cyc = cyc;
            b_drop     = 1'b1;
        end
        t = 0;
        while (b_fire_cyc < 0 && t < 20) begin
            step();
            t++;
        end
        chk({tag, " b accepted"}, b_fire_cyc >= 0, 1'b1);
        t = 0;
        do begin
            step();
            t++;
            if (abort_beat >= 0 && beats.size() >= abort_beat) begin
                step();
                reset_n = 1'b0;
                #1;
                chk_idle({tag, " in reset"});
                meta_pend = 1'b0; data_pend = 1'b0; hold_valid = 1'b0; b_fire_cyc = -1;
                step();
                step();
                reset_n = 1'b1;
                step();
                chk_idle({tag, " after reset"});
                return;
            end
        end while (busy && t < 400);
        chk({tag, " completes"}, busy, 1'b0);
        chk({tag, " meta idx"}, idx_seen, addr[11:6]);
        n_exp = exp_data ? BEATS : 1;
        chk({tag, " beat count"}, beats.size(), n_exp);
        for (int i = 0; i < beats.size() && i < n_exp; i++) begin
            chk($sformatf("%s beat%0d hdr", tag, i),
                {beats[i].op, beats[i].param, beats[i].src, beats[i].addr},
                {(exp_data ? 3'd5 : 3'd4), exp_param, src, addr});
            chk($sformatf("%s beat%0d data", tag, i), beats[i].data,
                exp_data ? line[i] : 64'h0);
        end
        chk({tag, " data reqs"}, dreq_cnt, exp_data ? BEATS : 0);
        chk({tag, " req order"}, order_err, 0);
        chk({tag, " c stable"}, stab_err, 0);
        chk({tag, " meta writes"}, wr_cnt, exp_wr);
        if (wr_cnt > 0) chk({tag, " meta write"}, {wr_way, wr_coh}, {hit_vec, exp_coh});
        chk({tag, " lsu pulses"}, lsu_cnt, exp_wr);
        chk({tag, " lsu on fire"}, lsu_bad, 0);
    endtask

    initial begin
        vec_t vecs[10];
        bit          d;
        logic [2:0]  rp;
        logic [1:0]  nc, cap, coh, eff;
        int          way;

        // cap, way(-1 miss), coh, has_data, report, meta write, new coh
        vecs[0] = '{2'd2,  2, 2'd3, 1'b1, 3'd1, 1'b1, 2'd0};
        vecs[1] = '{2'd1,  1, 2'd2, 1'b0, 3'd0, 1'b1, 2'd1};
        vecs[2] = '{2'd0, -1, 2'd3, 1'b0, 3'd5, 1'b0, 2'd0};
        vecs[3] = '{2'd0,  0, 2'd3, 1'b1, 3'd3, 1'b1, 2'd2};
        vecs[4] = '{2'd0,  3, 2'd2, 1'b0, 3'd3, 1'b0, 2'd2};
        vecs[5] = '{2'd1,  0, 2'd3, 1'b1, 3'd0, 1'b1, 2'd1};
        vecs[6] = '{2'd1,  2, 2'd1, 1'b0, 3'd4, 1'b0, 2'd1};
        vecs[7] = '{2'd2,  1, 2'd1, 1'b0, 3'd2, 1'b1, 2'd0};
        vecs[8] = '{2'd3,  3, 2'd2, 1'b0, 3'd1, 1'b1, 2'd0};
        vecs[9] = '{2'd2,  0, 2'd0, 1'b0, 3'd5, 1'b0, 2'd0};

        reset_n = 1'b0;
        b_valid = 1'b0; b_param = '0; b_addr = '0; b_source = '0;
        meta_req_ready = 1'b0; meta_resp_hit = '0; meta_resp_coh = '0; mshr_block = 1'b0;
        data_req_ready = 1'b0; data_resp = '0; c_ready = 1'b0; meta_wr_ready = 1'b0;
        b_drop = 1'b0; meta_pend = 1'b0; data_pend = 1'b0; hold_valid = 1'b0;
        b_fire_cyc = -1; cfg_rnd = 1'b0; cfg_k = 0; cfg_coh = '0; hit_vec = '0;
        repeat (3) @(negedge clock);
        chk_idle("reset");
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 10; i++) begin
            run_probe(vecs[i].cap, vecs[i].way, vecs[i].coh, 0, 1'b0, -1, vecs[i].data,
                      vecs[i].param, vecs[i].wr, vecs[i].ncoh, $sformatf("vec%0d", i));
        end

        // MSHR conflict: C must stay quiet until the cycle after mshr_block drops
        run_probe(2'd1, 1, 2'd2, 7, 1'b0, -1, 1'b0, 3'd0, 1'b1, 2'd1, "mshr");
        chk("mshr first c cycle", first_c - b_fire_cyc, 9);

        // Dirty toN with random backpressure on every ready
        run_probe(2'd2, 2, 2'd3, 0, 1'b1, -1, 1'b1, 3'd1, 1'b1, 2'd0, "cready_rnd");

        // Reset during beat 3, then a clean probe
        run_probe(2'd2, 2, 2'd3, 0, 1'b0, 3, 1'b1, 3'd1, 1'b1, 2'd0, "abort");
        run_probe(2'd2, 2, 2'd3, 0, 1'b0, -1, 1'b1, 3'd1, 1'b1, 2'd0, "post_abort");

        for (int i = 0; i < 25; i++) begin
            cap = 2'($urandom);
            coh = 2'($urandom);
            way = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 3));
            eff = (way < 0) ? 2'd0 : coh;
            ref_probe(cap, eff, d, rp, nc);
            run_probe(cap, way, coh, int'($urandom_range(0, 4)), 1'b1, -1, d, rp,
                      (way >= 0) && (nc != coh), nc, $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/probe_unit.md
Name: probe_unit

Overview:
- Services TileLink B-channel Probes for the L1 data cache.
- Sequences a probe through the metadata array, shrinks client coherence state using the shrink rules in the shared metadata package, and returns ProbeAck or ProbeAckData (with dirty data beats) on channel C.
- Sits between the TL B/C ports, the meta/data arrays and the MSHR file; one probe in flight at a time.

Parameters:
- ADDR_W, 32, physical address width
- DATA_W, 64, C-channel beat width
- BEATS, 8, beats per cache line
- WAYS, 4, associativity
- IDX_W, 6, set index width
- SRC_W, 4, TL source/size passthrough width

Ports:
- clock  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- b_valid/b_ready  in/out  1/1  probe handshake
- b_param  in  2  cap: toT=0, toB=1, toN=2
- b_addr  in  ADDR_W  line address
- b_source  in  SRC_W  echoed on C
- meta_req_valid/meta_req_ready  out/in  1/1  meta read
- meta_req_idx  out  IDX_W  set index
- meta_resp_hit  in  WAYS  one-hot tag match, valid the cycle after acceptance
- meta_resp_coh  in  2  hit-way state: Nothing=0, Branch=1, Trunk=2, Dirty=3
- mshr_block  in  1  conflicting MSHR busy on this line
- data_req_valid/data_req_ready  out/in  1/1  data beat read
- data_req_way  out  WAYS  way select
- data_req_beat  out  log2(BEATS)  beat index
- data_resp  in  DATA_W  data, valid the cycle after acceptance
- c_valid/c_ready  out/in  1/1  C handshake
- c_opcode  out  3  ProbeAck=4, ProbeAckData=5
- c_param  out  3  report: TtoB=0, TtoN=1, BtoN=2, TtoT=3, BtoB=4, NtoN=5
- c_addr  out  ADDR_W  line address
- c_source  out  SRC_W  echoed source
- c_data  out  DATA_W  beat data
- meta_wr_valid/meta_wr_ready  out/in  1/1  metadata write
- meta_wr_way  out  WAYS  way
- meta_wr_coh  out  2  new state
- busy  out  1  FSM not IDLE
- lsu_release  out  1  one-cycle pulse; LSU squashes speculative loads to c_addr

Behaviour:
- Reset: FSM=IDLE; all valids, busy, lsu_release = 0; registers cleared.
- IDLE: b_ready=1. On b fire, latch addr/param/source and go to META_RD.
- META_RD: meta_req_valid=1. On fire go to META_RESP.
- META_RESP (1 cycle): latch hit and coh; coh=Nothing on a miss. Compute {has_data, report, new_coh} from cap × coh:
  - toT: D→(1,TtoT,T), T→(0,TtoT,T), B→(0,BtoB,B), N→(0,NtoN,N)
  - toB: D→(1,TtoB,B), T→(0,TtoB,B), B→(0,BtoB,B), N→(0,NtoN,N)
  - toN: D→(1,TtoN,N), T→(0,TtoN,N), B→(0,BtoN,N), N→(0,NtoN,N)
  - The package's toN/Dirty entry is corrected to TtoN in the same change.
  - Next state: MSHR_WAIT.
- MSHR_WAIT: hold while mshr_block=1. Then go to DATA if has_data, else ACK.
- DATA: per beat, data_req fire, then the next cycle present c_valid with opcode=5 and data_resp captured into a 1-entry beat register.
  - Hold c_* stable until c_ready.
  - No new data_req issues while the beat register is full.
  - Beat counter wraps at BEATS-1. Last beat accepted goes to META_WR.
  - c_ready held low indefinitely: stall with no beat lost or duplicated.
- ACK: c_valid, opcode=4, c_data=0. On fire go to META_WR.
- META_WR: skipped (direct to IDLE) if miss or new_coh==coh. Otherwise meta_wr_valid with hit way; on fire go to IDLE.
- lsu_release pulses on the C fire of the ack or last beat whenever new_coh≠coh.
- Back-to-back probes: the next b fire occurs no earlier than the cycle after returning to IDLE.
- Unknown b_param (3) is treated as toN.
- reset_n assertion mid-operation aborts immediately; no partial meta write is retried.

Optional Feature:
- PROBE_UNIT_PERF_EN defined:
  - Adds 32-bit saturating counters probe_cnt, probe_data_cnt and stall_cyc (cycles in MSHR_WAIT or with c_valid&&!c_ready).
  - Exposed on output ports of those names; reset to 0.
- Undefined: counters and ports absent; behaviour otherwise identical.

Decomposition:
- Shared package: FSM state enum, TL opcode constants, report-param constants, coh encodings, and the shrink function (in the existing metadata package).
- One sub-module, probe_beat_buf: 1-entry data holding register with valid/ready.

Test Plan:
- Probe toN, hit Dirty way 2 → 8 ProbeAckData beats, param=TtoN, meta write way 2 coh=0, one lsu_release pulse.
- Probe toB, hit Trunk → ProbeAck param=TtoB, no data_req, meta write coh=1.
- Probe toT, miss → ProbeAck NtoN, no meta write, no lsu_release.
- mshr_block high 5 cycles → no C activity until the cycle after it drops.
- Dirty toN with c_ready toggled randomly → exactly 8 beats in order 0..7, data matches array.
- reset_n pulsed during beat 3 → all outputs 0, FSM IDLE, next probe completes normally.
